// File: rtl/axi_sram_slave.sv
// ---------------------------------------------------------------------------
// axi_sram_slave
//   AXI3-style single-port memory responder. One transaction at a time.
//   Read wins over write when both address channels are valid in IDLE.
//   INCR and FIXED bursts of up to 256 beats with 32-bit data and byte strobes.
//   Bursts with size != 4 bytes or of type WRAP are flagged as errors. They
//   still move data as INCR with 4-byte steps, and they answer with SLVERR.
//
// Ports
//   aclk, aresetn        clock and asynchronous active-low reset
//   ar*                  read address channel  (arid, araddr, arlen, arsize, arburst)
//   r*                   read data channel     (rid, rdata, rresp, rlast)
//   aw*                  write address channel (awid, awaddr, awlen, awsize, awburst)
//   w*                   write data channel    (wid is ignored)
//   b*                   write response channel (bid, bresp)
//
// Memory is 2**MEM_AW 32-bit words. The word index is addr[MEM_AW+1:2], so
// higher address bits alias.
// ---------------------------------------------------------------------------
module axi_sram_slave #(
    parameter int MEM_AW = 14,
    parameter int ID_W   = 4
) (
    input  logic            aclk,
    input  logic            aresetn,
    input  logic [ID_W-1:0] arid,
    input  logic [31:0]     araddr,
    input  logic [7:0]      arlen,
    input  logic [2:0]      arsize,
    input  logic [1:0]      arburst,
    input  logic            arvalid,
    output logic            arready,
    output logic [ID_W-1:0] rid,
    output logic [31:0]     rdata,
    output logic [1:0]      rresp,
    output logic            rlast,
    output logic            rvalid,
    input  logic            rready,
    input  logic [ID_W-1:0] awid,
    input  logic [31:0]     awaddr,
    input  logic [7:0]      awlen,
    input  logic [2:0]      awsize,
    input  logic [1:0]      awburst,
    input  logic            awvalid,
    output logic            awready,
    input  logic [ID_W-1:0] wid,
    input  logic [31:0]     wdata,
    input  logic [3:0]      wstrb,
    input  logic            wlast,
    input  logic            wvalid,
    output logic            wready,
    output logic [ID_W-1:0] bid,
    output logic [1:0]      bresp,
    output logic            bvalid,
    input  logic            bready
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RD    = 2'd1;
    localparam logic [1:0] ST_WR    = 2'd2;
    localparam logic [1:0] ST_WRESP = 2'd3;
    localparam int         DEPTH    = 1 << MEM_AW;
    localparam logic [1:0] RESP_OK  = 2'b00;
    localparam logic [1:0] RESP_ERR = 2'b10;

    logic [1:0]        state_q, state_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic              fixed_q, fixed_d;
    logic              err_q, err_d;
    logic              wlast_err_q, wlast_err_d;
    logic              rvalid_q, rvalid_d;
    logic              rlast_q, rlast_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [ID_W-1:0]   rid_q, rid_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic [ID_W-1:0]   bid_q, bid_d;

    logic              rd_en;
    logic [MEM_AW-1:0] rd_idx;
    logic              we;
    logic [MEM_AW-1:0] next_idx;
    logic              ar_err;
    logic              aw_err;
    logic              beat_last;
    logic              wlast_bad;
    logic [31:0]       mem_rdata;

    // Inputs that carry no information for this responder.
    logic unused_inputs;
    assign unused_inputs = ^{wid, araddr[31:MEM_AW+2], araddr[1:0],
                             awaddr[31:MEM_AW+2], awaddr[1:0]};

    assign ar_err    = (arsize != 3'd2) || (arburst == 2'b10);
    assign aw_err    = (awsize != 3'd2) || (awburst == 2'b10);
    // Erroring bursts are never treated as FIXED, so they step like INCR.
    assign next_idx  = fixed_q ? addr_q : addr_q + {{(MEM_AW-1){1'b0}}, 1'b1};
    assign beat_last = (cnt_q == len_q);
    assign wlast_bad = (wlast != beat_last);
    assign we        = (state_q == ST_WR) && wvalid;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        fixed_d     = fixed_q;
        err_d       = err_q;
        wlast_err_d = wlast_err_q;
        rvalid_d    = rvalid_q;
        rlast_d     = rlast_q;
        rresp_d     = rresp_q;
        rid_d       = rid_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        bid_d       = bid_q;
        rd_en       = 1'b0;
        rd_idx      = next_idx;

        case (state_q)
            ST_IDLE: begin
                if (arvalid) begin
                    // The first beat is read on the handshake edge itself so
                    // that rvalid shows up on the very next cycle.
                    state_d  = ST_RD;
                    rid_d    = arid;
                    len_d    = arlen;
                    cnt_d    = 8'd0;
                    err_d    = ar_err;
                    fixed_d  = (arburst == 2'b00) && !ar_err;
                    addr_d   = araddr[MEM_AW+1:2];
                    rd_en    = 1'b1;
                    rd_idx   = araddr[MEM_AW+1:2];
                    rvalid_d = 1'b1;
                    rlast_d  = (arlen == 8'd0);
                    rresp_d  = ar_err ? RESP_ERR : RESP_OK;
                end else if (awvalid) begin
                    state_d     = ST_WR;
                    bid_d       = awid;
                    len_d       = awlen;
                    cnt_d       = 8'd0;
                    err_d       = aw_err;
                    fixed_d     = (awburst == 2'b00) && !aw_err;
                    addr_d      = awaddr[MEM_AW+1:2];
                    wlast_err_d = 1'b0;
                end
            end
            ST_RD: begin
                if (rready) begin
                    if (rlast_q) begin
                        rvalid_d = 1'b0;
                        rlast_d  = 1'b0;
                        state_d  = ST_IDLE;
                    end else begin
                        // Fetch the following beat; the read register only
                        // changes here, which keeps rdata stable under stall.
                        cnt_d   = cnt_q + 8'd1;
                        addr_d  = next_idx;
                        rd_en   = 1'b1;
                        rd_idx  = next_idx;
                        rlast_d = ((cnt_q + 8'd1) == len_q);
                    end
                end
            end
            ST_WR: begin
                if (wvalid) begin
                    if (beat_last) begin
                        // The burst length alone decides the end of the burst.
                        state_d  = ST_WRESP;
                        bvalid_d = 1'b1;
                        bresp_d  = (err_q || wlast_err_q || wlast_bad) ? RESP_ERR : RESP_OK;
                    end else begin
                        cnt_d       = cnt_q + 8'd1;
                        addr_d      = next_idx;
                        wlast_err_d = wlast_err_q || wlast_bad;
                    end
                end
            end
            default: begin
                if (bready) begin
                    bvalid_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            addr_q      <= '0;
            fixed_q     <= 1'b0;
            err_q       <= 1'b0;
            wlast_err_q <= 1'b0;
            rvalid_q    <= 1'b0;
            rlast_q     <= 1'b0;
            rresp_q     <= RESP_OK;
            rid_q       <= '0;
            bvalid_q    <= 1'b0;
            bresp_q     <= RESP_OK;
            bid_q       <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            fixed_q     <= fixed_d;
            err_q       <= err_d;
            wlast_err_q <= wlast_err_d;
            rvalid_q    <= rvalid_d;
            rlast_q     <= rlast_d;
            rresp_q     <= rresp_d;
            rid_q       <= rid_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            bid_q       <= bid_d;
        end
    end

    // One byte-wide array per lane, so byte strobes map onto plain
    // write enables. The array contents survive reset.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] lane_rd_q;
            always_ff @(posedge aclk) begin
                if (we && wstrb[gi]) begin
                    lane_mem[addr_q] <= wdata[8*gi +: 8];
                end
                if (rd_en) begin
                    lane_rd_q <= lane_mem[rd_idx];
                end
            end
            assign mem_rdata[8*gi +: 8] = lane_rd_q;
        end
    endgenerate

    assign arready = (state_q == ST_IDLE);
    assign awready = (state_q == ST_IDLE) && !arvalid;
    assign wready  = (state_q == ST_WR);
    assign rvalid  = rvalid_q;
    assign rlast   = rlast_q;
    assign rresp   = rresp_q;
    assign rid     = rid_q;
    assign rdata   = rvalid_q ? mem_rdata : 32'd0;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign bid     = bid_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_sram_slave
//   Directed and randomized bursts against a word-array reference memory.
//   Expected read data, responses and last flags come from the burst rules
//   (beat address, error flag, strobes) applied to the reference array.
// ---------------------------------------------------------------------------
module tb_axi_sram_slave;

    localparam int TB_AW = 10;
    localparam int DEPTH = 1 << TB_AW;

    logic        aclk;
    logic        aresetn;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    axi_sram_slave #(.MEM_AW(TB_AW), .ID_W(4)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int unsigned vec_cnt  = 0;
    int unsigned miss_cnt = 0;

    logic [31:0] ref_mem [DEPTH];
    logic [31:0] wd [256];
    logic [3:0]  ws [256];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            miss_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // Word touched by beat i of a burst.
    function automatic int unsigned beat_idx(input logic [31:0] addr, input int i,
                                             input logic [2:0] size, input logic [1:0] burst);
        int unsigned base;
        bit          err;
        err  = (size != 3'd2) || (burst == 2'b10);
        base = int'(addr[TB_AW+1:2]);
        if (!err && burst == 2'b00) return base;
        return (base + i) % DEPTH;
    endfunction

    function automatic logic [1:0] exp_resp(input logic [2:0] size, input logic [1:0] burst);
        return ((size != 3'd2) || (burst == 2'b10)) ? 2'b10 : 2'b00;
    endfunction

    task automatic fill_rand(input int n);
        for (int i = 0; i < n; i++) begin
            wd[i] = $urandom;
            ws[i] = 4'($urandom_range(0, 15));
        end
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input bit early, input bit miss_last, input int bdelay);
        int   n;
        bit   bad;
        int unsigned idx;
        logic [1:0] er;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 100) begin step(); n++; end
        chk("aw_handshake", {31'd0, awready}, 32'd1);
        step();
        awvalid = 1'b0;
        bad = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i]; wid = id;
            wlast  = (i == int'(len)) ? !miss_last : (early && i == 0);
            if (wlast != (i == int'(len))) bad = 1'b1;
            n = 0;
            while (!wready && n < 100) begin step(); n++; end
            chk("wready_beat", {31'd0, wready}, 32'd1);
            idx = beat_idx(addr, i, size, burst);
            for (int b = 0; b < 4; b++)
                if (ws[i][b]) ref_mem[idx][8*b +: 8] = wd[i][8*b +: 8];
            step();
        end
        wvalid = 1'b0; wlast = 1'b0;
        chk("wready_after_last", {31'd0, wready}, 32'd0);
        n = 0;
        while (!bvalid && n < 100) begin step(); n++; end
        er = exp_resp(size, burst) | (bad ? 2'b10 : 2'b00);
        chk("bvalid", {31'd0, bvalid}, 32'd1);
        chk("bid", {28'd0, bid}, {28'd0, id});
        chk("bresp", {30'd0, bresp}, {30'd0, er});
        for (int d = 0; d < bdelay; d++) begin
            step();
            chk("bvalid_hold", {31'd0, bvalid}, 32'd1);
        end
        bready = 1'b1;
        step();
        bready = 1'b0;
        chk("bvalid_clear", {31'd0, bvalid}, 32'd0);
        $display("wr id=%0h addr=%h len=%0d size=%0d burst=%0d bresp=%0d", id, addr, len, size, burst, bresp);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int rmode);
        int n;
        int beat;
        int cyc;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 100) begin step(); n++; end
        chk("ar_handshake", {31'd0, arready}, 32'd1);
        step();
        arvalid = 1'b0;
        chk("rvalid_first", {31'd0, rvalid}, 32'd1);
        beat = 0;
        cyc  = 0;
        while (beat <= int'(len) && cyc < 4000) begin
            case (rmode)
                0:       rready = 1'b1;
                1:       rready = (cyc % 3 == 0);
                default: rready = 1'($urandom_range(0, 1));
            endcase
            if (rvalid !== 1'b1) begin
                chk("rvalid_beat", {31'd0, rvalid}, 32'd1);
                break;
            end
            chk("rdata", rdata, ref_mem[beat_idx(addr, beat, size, burst)]);
            chk("rlast", {31'd0, rlast}, {31'd0, beat == int'(len)});
            chk("rresp", {30'd0, rresp}, {30'd0, exp_resp(size, burst)});
            chk("rid", {28'd0, rid}, {28'd0, id});
            if (rready) beat++;
            step();
            cyc++;
        end
        rready = 1'b0;
        chk("read_beats", beat, 32'(int'(len) + 1));
        chk("rvalid_end", {31'd0, rvalid}, 32'd0);
        $display("rd id=%0h addr=%h len=%0d size=%0d burst=%0d mode=%0d", id, addr, len, size, burst, rmode);
    endtask

    initial begin
        logic [31:0] a;
        logic [7:0]  l;
        logic [2:0]  sz;
        logic [1:0]  bu;
        aresetn = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        repeat (3) step();

        // Reset values.
        chk("rst_arready", {31'd0, arready}, 32'd1);
        chk("rst_awready", {31'd0, awready}, 32'd1);
        chk("rst_wready", {31'd0, wready}, 32'd0);
        chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst_rlast", {31'd0, rlast}, 32'd0);
        chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
        chk("rst_rid_bid", {24'd0, rid, bid}, 32'd0);
        chk("rst_resp", {28'd0, rresp, bresp}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        aresetn = 1'b1;
        step();

        // Fill all words with 256-beat INCR bursts.
        for (int blk = 0; blk < 4; blk++) begin
            for (int i = 0; i < 256; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
            do_write(4'(blk), 32'(blk * 1024), 8'd255, 3'd2, 2'b01, 1'b0, 1'b0, 0);
        end

        // INCR write then back-to-back read.
        wd[0] = 32'h11111111; wd[1] = 32'h22222222; wd[2] = 32'h33333333; wd[3] = 32'h44444444;
        for (int i = 0; i < 4; i++) ws[i] = 4'hF;
        do_write(4'h5, 32'h100, 8'd3, 3'd2, 2'b01, 1'b0, 1'b0, 2);
        do_read(4'h6, 32'h100, 8'd3, 3'd2, 2'b01, 0);

        // Strobes with a FIXED burst.
        wd[0] = 32'hAABBCCDD; ws[0] = 4'hF;
        do_write(4'h1, 32'h200, 8'd0, 3'd2, 2'b01, 1'b0, 1'b0, 0);
        wd[0] = 32'h11223344; ws[0] = 4'b0001;
        wd[1] = 32'h55667788; ws[1] = 4'b0100;
        do_write(4'h2, 32'h200, 8'd1, 3'd2, 2'b00, 1'b0, 1'b0, 0);
        do_read(4'h3, 32'h200, 8'd0, 3'd2, 2'b01, 0);

        // R backpressure with rready 1,0,0,...
        do_read(4'h7, 32'h300, 8'd7, 3'd2, 2'b01, 1);

        // Priority: AR and AW raised together.
        fill_rand(3);
        awid = 4'h9; awaddr = 32'h180; awlen = 8'd2; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
        do_read(4'h8, 32'h040, 8'd2, 3'd2, 2'b01, 0);
        chk("aw_after_read", {31'd0, awready}, 32'd1);
        do_write(4'h9, 32'h180, 8'd2, 3'd2, 2'b01, 1'b0, 1'b0, 0);
        do_read(4'h9, 32'h180, 8'd2, 3'd2, 2'b01, 2);

        // Error responses.
        do_read(4'hA, 32'h020, 8'd3, 3'd1, 2'b01, 0);
        do_read(4'hB, 32'h3F0, 8'd7, 3'd2, 2'b10, 0);
        fill_rand(3);
        do_write(4'hC, 32'h500, 8'd2, 3'd2, 2'b01, 1'b1, 1'b0, 0);
        fill_rand(2);
        do_write(4'hD, 32'h520, 8'd1, 3'd2, 2'b01, 1'b0, 1'b1, 0);
        do_read(4'hE, 32'h500, 8'd9, 3'd2, 2'b01, 0);

        // Reset mid read burst: handshake is aborted, memory kept.
        arid = 4'h4; araddr = 32'h040; arlen = 8'd15; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        rready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("pre_rst_rdata", rdata, ref_mem[beat_idx(32'h040, i, 3'd2, 2'b01)]);
            step();
        end
        rready = 1'b0;
        #2 aresetn = 1'b0;
        #1;
        chk("rst_mid_rvalid", {31'd0, rvalid}, 32'd0);
        step();
        chk("rst_mid_rvalid_next", {31'd0, rvalid}, 32'd0);
        chk("rst_mid_arready", {31'd0, arready}, 32'd1);
        aresetn = 1'b1;
        step();
        $display("rst mid-burst applied");
        do_read(4'h4, 32'h040, 8'd15, 3'd2, 2'b01, 2);

        // Randomized traffic, including aliased high address bits.
        for (int t = 0; t < 30; t++) begin
            a  = $urandom;
            l  = 8'($urandom_range(0, 15));
            bu = 2'($urandom_range(0, 2));
            sz = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 3)) : 3'd2;
            if ($urandom_range(0, 1) == 1) begin
                fill_rand(int'(l) + 1);
                do_write(4'($urandom), a, l, sz, bu, ($urandom_range(0, 7) == 0),
                         ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)));
            end else begin
                do_read(4'($urandom), a, l, sz, bu, int'($urandom_range(0, 2)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
